pixel_write_queue: RTL and testbench

- Receiving end of the sprite/tile pixel-plot stream (X, Y, Color, Plot strobe) produced by the sprite drawers.
- Buffers plotted pixels in a small FIFO, converts (X,Y) to a linear framebuffer address, and drains entries into the framebuffer write port.
- The write port may stall when the scan-out side holds FbBusy.
- Drawers never stall; loss is reported, not back-pressured.

---
 rtl/pixel_write_queue_pkg.sv | 30 +++
 rtl/pixel_write_queue_fifo.sv | 89 ++++++++
 rtl/pixel_write_queue.sv | 141 ++++++++++++++
 tb/tb_pixel_write_queue.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_write_queue_pkg.sv
// Shared constants, types and address helper for the pixel write queue and sprite drawers.
package pixel_write_queue_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned FB_AW    = 15;
    localparam int unsigned COLOR_W  = 9;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;

    // Colour the drawers treat as transparent (never plotted)
    localparam logic [COLOR_W-1:0] TRANSPARENT_COLOR = 9'b100101110;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } wr_state_e;

    typedef struct packed {
        logic [FB_AW-1:0]   addr;
        logic [COLOR_W-1:0] color;
    } fb_entry_t;

    // Linear address Y*160+X built from shifts, truncated to FB_AW bits
    function automatic logic [FB_AW-1:0] pixel_addr(input logic [X_W-1:0] x,
                                                    input logic [Y_W-1:0] y);
        return (FB_AW'(y) << 7) + (FB_AW'(y) << 5) + FB_AW'(x);
    endfunction

endpackage

// File: rtl/pixel_write_queue_fifo.sv
// Synchronous FIFO of framebuffer entries; exposes head and the entry behind it.
module pixel_fifo
    import pixel_write_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  fb_entry_t                wr_data_i,
    input  logic                     pop_i,
    output fb_entry_t                head_o,
    output fb_entry_t                head_next_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fb_entry_t         mem_q [DEPTH];
    fb_entry_t         mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     rd_ptr_nx;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              push_ok;
    logic              pop_ok;

    // Pointer, occupancy and storage next-state
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        push_ok   = push_i && !full_q;
        pop_ok    = pop_i && !empty_q;
        rd_ptr_nx = AW'(rd_ptr_q + AW'(1));

        if (push_ok) begin
            mem_d[wr_ptr_q] = wr_data_i;
            wr_ptr_d        = AW'(wr_ptr_q + AW'(1));
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_nx;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = CW'(count_q + CW'(1));
            2'b01:   count_d = CW'(count_q - CW'(1));
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == CW'(0));
    end

    // Entry storage (data only, not reset)
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign head_o      = mem_q[rd_ptr_q];
    assign head_next_o = mem_q[rd_ptr_nx];
    assign count_o     = count_q;
    assign full_o      = full_q;
    assign empty_o     = empty_q;

endmodule

// File: rtl/pixel_write_queue.sv
// Pixel write queue: buffers plotted pixels and drains them into the framebuffer port.
// Optional PIXEL_CLIP_EN discards pixels outside the visible screen.
module pixel_write_queue
    import pixel_write_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [X_W-1:0]           X,
    input  logic [Y_W-1:0]           Y,
    input  logic [COLOR_W-1:0]       Color,
    input  logic                     Plot,
    input  logic                     ClearOverflow,
    input  logic                     FbBusy,
    output logic [FB_AW-1:0]         FbAddress,
    output logic [COLOR_W-1:0]       FbData,
    output logic                     FbWrite,
    output logic                     Full,
    output logic                     Empty,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Overflow
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    wr_state_e            state_q, state_d;
    logic [FB_AW-1:0]     fb_addr_q, fb_addr_d;
    logic [COLOR_W-1:0]   fb_data_q, fb_data_d;
    logic                 fb_write_q, fb_write_d;
    logic                 overflow_q, overflow_d;

    logic                 in_range;
    logic                 push;
    logic                 pop;
    logic                 drop;
    fb_entry_t            wr_entry;
    fb_entry_t            head;
    fb_entry_t            head_next;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;

`ifdef PIXEL_CLIP_EN
    assign in_range = (X < X_W'(SCREEN_W)) && (Y < Y_W'(SCREEN_H));
`else
    assign in_range = 1'b1;
`endif

    // Enqueue/drop decision and stored entry
    always_comb begin
        push           = Plot && in_range && !fifo_full;
        drop           = Plot && in_range && fifo_full;
        wr_entry.addr  = pixel_addr(X, Y);
        wr_entry.color = Color;
    end

    pixel_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk         (Clock),
        .rst         (Reset),
        .push_i      (push),
        .wr_data_i   (wr_entry),
        .pop_i       (pop),
        .head_o      (head),
        .head_next_o (head_next),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Write FSM next-state and registered port values; a drop beats a clear
    always_comb begin
        state_d    = state_q;
        fb_addr_d  = fb_addr_q;
        fb_data_d  = fb_data_q;
        fb_write_d = 1'b0;
        pop        = 1'b0;
        overflow_d = overflow_q;

        if (drop) begin
            overflow_d = 1'b1;
        end else if (ClearOverflow) begin
            overflow_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d    = ISSUE;
                    fb_addr_d  = head.addr;
                    fb_data_d  = head.color;
                    fb_write_d = 1'b1;
                end
            end
            ISSUE: begin
                fb_write_d = 1'b1;
                if (!FbBusy) begin
                    pop = 1'b1;
                    if (fifo_count > CW'(1)) begin
                        fb_addr_d = head_next.addr;
                        fb_data_d = head_next.color;
                    end else begin
                        state_d    = IDLE;
                        fb_write_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
            fb_write_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
            fb_write_q <= fb_write_d;
            overflow_q <= overflow_d;
        end
    end

    assign FbAddress = fb_addr_q;
    assign FbData    = fb_data_q;
    assign FbWrite   = fb_write_q;
    assign Full      = fifo_full;
    assign Empty     = fifo_empty;
    assign Count     = fifo_count;
    assign Overflow  = overflow_q;

endmodule

// File: tb/tb_pixel_write_queue.sv
// Directed bench for pixel_write_queue with a scoreboard of expected framebuffer writes.
module tb_pixel_write_queue;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [7:0]  X = '0;
    logic [6:0]  Y = '0;
    logic [8:0]  Color = '0;
    logic        Plot = 1'b0;
    logic        ClearOverflow = 1'b0;
    logic        FbBusy = 1'b0;
    logic [14:0] FbAddress;
    logic [8:0]  FbData;
    logic        FbWrite;
    logic        Full;
    logic        Empty;
    logic [3:0]  Count;
    logic        Overflow;

    int          checks = 0;
    int          errors = 0;
    int          writes = 0;
    logic [23:0] sb [$];
    logic [23:0] mon_e;

    pixel_write_queue #(.DEPTH(8)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .X             (X),
        .Y             (Y),
        .Color         (Color),
        .Plot          (Plot),
        .ClearOverflow (ClearOverflow),
        .FbBusy        (FbBusy),
        .FbAddress     (FbAddress),
        .FbData        (FbData),
        .FbWrite       (FbWrite),
        .Full          (Full),
        .Empty         (Empty),
        .Count         (Count),
        .Overflow      (Overflow)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic plot(input int x, input int y, input int c);
        X     = 8'(x);
        Y     = 7'(y);
        Color = 9'(c);
        Plot  = 1'b1;
    endtask

    task automatic expect_px(input int x, input int y, input int c);
        int a;
        a = y * 160 + x;
        sb.push_back({15'(a), 9'(c)});
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40; i++) begin
            if (Empty && !FbWrite) break;
            step();
        end
        check("drain_timeout", {30'd0, Empty, FbWrite}, 32'd2);
    endtask

    // Every committed write must match the oldest outstanding plot
    always @(negedge Clock) begin
        if (!Reset && FbWrite && !FbBusy) begin
            writes++;
            if (sb.size() == 0) begin
                check("sb_empty_on_write", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                check("fb_address", 32'(FbAddress), 32'(mon_e[23:9]));
                check("fb_data", 32'(FbData), 32'(mon_e[8:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset state
        Reset = 1'b1;
        step();
        step();
        check("rst_fbwrite", 32'(FbWrite), 32'd0);
        check("rst_fbaddr", 32'(FbAddress), 32'd0);
        check("rst_fbdata", 32'(FbData), 32'd0);
        check("rst_count", 32'(Count), 32'd0);
        check("rst_empty", 32'(Empty), 32'd1);
        check("rst_full", 32'(Full), 32'd0);
        check("rst_overflow", 32'(Overflow), 32'd0);
        Reset = 1'b0;
        step();

        // Single pixel latency
        plot(3, 2, 9'h1FF);
        expect_px(3, 2, 9'h1FF);
        step();
        Plot = 1'b0;
        check("t1_early_write", 32'(FbWrite), 32'd0);
        check("t1_count", 32'(Count), 32'd1);
        step();
        check("t1_write", 32'(FbWrite), 32'd1);
        check("t1_addr", 32'(FbAddress), 32'd323);
        check("t1_data", 32'(FbData), 32'h1FF);
        step();
        check("t1_empty", 32'(Empty), 32'd1);
        check("t1_idle", 32'(FbWrite), 32'd0);

        // Burst under stall, overflow, clear priority
        FbBusy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            plot(i, 0, 100 + i);
            expect_px(i, 0, 100 + i);
            step();
        end
        Plot = 1'b0;
        check("t2_count", 32'(Count), 32'd8);
        check("t2_full", 32'(Full), 32'd1);
        check("t2_no_ovf", 32'(Overflow), 32'd0);
        plot(8, 0, 1);
        step();
        Plot = 1'b0;
        check("t2_ovf_set", 32'(Overflow), 32'd1);
        check("t2_count_hold", 32'(Count), 32'd8);
        plot(9, 0, 2);
        ClearOverflow = 1'b1;
        step();
        Plot = 1'b0;
        check("t2_drop_and_clear", 32'(Overflow), 32'd1);
        step();
        ClearOverflow = 1'b0;
        check("t2_clear", 32'(Overflow), 32'd0);
        FbBusy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("t2_burst_write", 32'(FbWrite), 32'd1);
            check("t2_burst_addr", 32'(FbAddress), 32'(i));
            step();
        end
        check("t2_empty", 32'(Empty), 32'd1);
        check("t2_idle", 32'(FbWrite), 32'd0);

        // Concurrent push and pop at Count=3
        FbBusy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            plot(20 + i, 1, 200 + i);
            expect_px(20 + i, 1, 200 + i);
            step();
        end
        Plot = 1'b0;
        check("t3_count_pre", 32'(Count), 32'd3);
        FbBusy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            plot(30 + i, 3, 300 + i);
            expect_px(30 + i, 3, 300 + i);
            step();
            check("t3_count_steady", 32'(Count), 32'd3);
        end
        Plot = 1'b0;
        check("t3_no_ovf", 32'(Overflow), 32'd0);
        wait_drain();

`ifdef PIXEL_CLIP_EN
        // Out-of-range pixels discarded, corner pixel kept
        plot(160, 5, 9'h011);
        step();
        plot(10, 120, 9'h022);
        step();
        Plot = 1'b0;
        check("t4_clip_count", 32'(Count), 32'd0);
        check("t4_clip_ovf", 32'(Overflow), 32'd0);
        check("t4_clip_empty", 32'(Empty), 32'd1);
        plot(159, 119, 9'h0AB);
        expect_px(159, 119, 9'h0AB);
        step();
        Plot = 1'b0;
        step();
        check("t4_corner_addr", 32'(FbAddress), 32'd19199);
        wait_drain();
`else
        // Without clipping an out-of-range column is still enqueued
        plot(160, 5, 9'h011);
        expect_px(160, 5, 9'h011);
        step();
        Plot = 1'b0;
        check("t4_noclip_count", 32'(Count), 32'd1);
        step();
        check("t4_noclip_addr", 32'(FbAddress), 32'd960);
        wait_drain();
`endif

        // Reset while a write is pending
        FbBusy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            plot(40 + i, 4, 400 + i);
            step();
        end
        Plot = 1'b0;
        check("t5_count_pre", 32'(Count), 32'd4);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("t5_fbwrite", 32'(FbWrite), 32'd0);
        check("t5_count", 32'(Count), 32'd0);
        check("t5_ovf", 32'(Overflow), 32'd0);
        check("t5_empty", 32'(Empty), 32'd1);
        FbBusy = 1'b0;
        plot(1, 1, 9'h055);
        expect_px(1, 1, 9'h055);
        step();
        Plot = 1'b0;
        wait_drain();

        repeat (3) step();
        check("sb_leftover", 32'(sb.size()), 32'd0);
        check("total_writes", 32'(writes), 32'd24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
